// File: rtl/truncator_sequencer_if.sv
// Bus between the frame-phase sequencer and the truncator / priority-encoder side.
// Ports (slave = sequencer view):
//   in : frame_clock, enable, latch_phase[1:0], cnt_reset, segment_active[MXSEGS-1:0]
//   out: latch_en[MXSEGS-1:0], locked, frame_start, step_valid, step_index[1:0],
//        frame_saturated, sat_count[CNT_BITS-1:0]
interface truncator_sequencer_if #(
  parameter int unsigned MXSEGS   = 12,
  parameter int unsigned CNT_BITS = 16
);
  logic                frame_clock;
  logic                enable;
  logic [1:0]          latch_phase;
  logic                cnt_reset;
  logic [MXSEGS-1:0]   segment_active;
  logic [MXSEGS-1:0]   latch_en;
  logic                locked;
  logic                frame_start;
  logic                step_valid;
  logic [1:0]          step_index;
  logic                frame_saturated;
  logic [CNT_BITS-1:0] sat_count;

  modport master (
    output frame_clock, enable, latch_phase, cnt_reset, segment_active,
    input  latch_en, locked, frame_start, step_valid, step_index,
           frame_saturated, sat_count
  );

  modport slave (
    input  frame_clock, enable, latch_phase, cnt_reset, segment_active,
    output latch_en, locked, frame_start, step_valid, step_index,
           frame_saturated, sat_count
  );
endinterface

// File: rtl/truncator_sequencer.sv
// Frame-phase controller for the 160 MHz cluster truncator.
// Detects 40 MHz frame edges, locks onto a 4-cycle frame, issues the once-per-frame
// truncator load strobe, sequences the four truncation steps and counts saturated frames.
// Ports:
//   clock, reset     : 160 MHz clock, synchronous active-high reset
//   bus (slave)      : frame_clock/enable/latch_phase/cnt_reset/segment_active in;
//                      latch_en/locked/frame_start/step_valid/step_index/
//                      frame_saturated/sat_count out
module truncator_sequencer #(
  parameter int unsigned MXSEGS     = 12,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  truncator_sequencer_if.slave  bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT) + 1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t         state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [2:0]          fc_q;
  logic [1:0]          ph_q;
  logic [MXSEGS-1:0]   latch_en_q;
  logic                in_frame_q, in_frame_d;
  logic [1:0]          step_q, step_d;
  logic [CNT_BITS-1:0] sat_q, sat_d;

  logic rise;
  logic ph_last;
  logic lock_lost;
  logic req;
  logic load;
  logic step_valid_c;
  logic frame_sat_c;

  assign rise    = fc_q[1] & ~fc_q[2];
  assign ph_last = (ph_q == 2'd3);
  assign load    = latch_en_q[0];

  // Lock state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock next-state: a good edge is a rise exactly when the phase counter wraps
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      UNLOCKED: begin
        if (rise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (rise && ph_last) begin
          if (good_q == GOOD_W'(LOCK_COUNT - 1)) state_d = LOCKED;
          else                                   good_d  = good_q + GOOD_W'(1);
        end else if (rise) begin
          good_d = '0;
        end else if (ph_last) begin
          state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        // Edge off-phase or missing edge at the wrap point both break lock
        if (rise != ph_last) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign lock_lost = (state_q == LOCKED) && (state_d != LOCKED);
  assign req       = (state_q == LOCKED) & bus.enable & (ph_q == bus.latch_phase);

  // Frame step sequencing; lock loss abandons the frame even if a load lands now
  always_comb begin
    in_frame_d = in_frame_q;
    step_d     = step_q;
    if (lock_lost) begin
      in_frame_d = 1'b0;
    end else if (load) begin
      in_frame_d = 1'b1;
      step_d     = 2'd0;
    end else if (in_frame_q) begin
      if (step_q != 2'd3) step_d     = step_q + 2'd1;
      else                in_frame_d = 1'b0;
    end
  end

  assign step_valid_c = in_frame_q & (|bus.segment_active);
  assign frame_sat_c  = step_valid_c & (step_q == 2'd3);

  // Saturating counter of fully used frames; clear wins over increment
  always_comb begin
    sat_d = sat_q;
    if (bus.cnt_reset)              sat_d = '0;
    else if (frame_sat_c && !(&sat_q)) sat_d = sat_q + CNT_BITS'(1);
  end

  // Edge detector, phase counter, strobe and frame datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      fc_q       <= '0;
      ph_q       <= '0;
      latch_en_q <= '0;
      in_frame_q <= 1'b0;
      step_q     <= '0;
      sat_q      <= '0;
    end else begin
      fc_q       <= {fc_q[1:0], bus.frame_clock};
      ph_q       <= rise ? 2'd0 : ph_q + 2'd1;
      latch_en_q <= {MXSEGS{req}};
      in_frame_q <= in_frame_d;
      step_q     <= step_d;
      sat_q      <= sat_d;
    end
  end

  assign bus.latch_en        = latch_en_q;
  assign bus.locked          = (state_q == LOCKED);
  assign bus.frame_start     = in_frame_q & (step_q == 2'd0);
  assign bus.step_valid      = step_valid_c;
  assign bus.step_index      = step_q;
  assign bus.frame_saturated = frame_sat_c;
  assign bus.sat_count       = sat_q;

endmodule

// File: doc/truncator_sequencer.md
# truncator_sequencer

Frame-phase controller for the 160 MHz cluster truncator. It derives the once-per-frame load strobe from the 40 MHz frame clock and gates it with a lock state machine. It sequences the four truncation steps of each frame, tells the downstream priority-encoder pipeline which step holds a valid cluster, and counts frames that use all four slots.

## Interface
- MXSEGS, 12: number of truncator segments; width of `segment_active` and `latch_en`.
- LOCK_COUNT, 4: consecutive correctly spaced frame edges required to reach LOCKED.
- CNT_BITS, 16: width of the saturated-frame counter.
- clock  in  1  160 MHz logic clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- frame_clock  in  1  40 MHz frame clock, sampled as data in the `clock` domain.
- enable  in  1  allows `latch_en` generation; sampled each cycle.
- latch_phase  in  2  phase count on which the load strobe is requested.
- cnt_reset  in  1  synchronous clear of `sat_count`.
- segment_active  in  MXSEGS  per-segment non-empty flags from the truncator flip-flops.
- latch_en  out  MXSEGS  registered, replicated load strobe to the truncator.
- locked  out  1  high in the LOCKED state.
- frame_start  out  1  one-cycle pulse, coincident with the first step of a frame.
- step_valid  out  1  the current truncator contents hold a cluster for the encoder.
- step_index  out  2  slot number 0..3 within the frame.
- frame_saturated  out  1  one-cycle pulse when slot 3 is valid.
- sat_count  out  CNT_BITS  saturating count of `frame_saturated` pulses.

## Operation
- **Edge detect.** `frame_clock` shifts into a 3-bit register `fc[2:0]`. `rise = fc[1] & ~fc[2]`.
- **Phase counter.** `ph` is 2 bits. It loads 0 on a clock edge where `rise` is high; otherwise it increments and wraps 3->0.
- **Lock FSM states.** UNLOCKED, CHECK, LOCKED. `good` is a counter with log2(LOCK_COUNT)+1 bits.
- **UNLOCKED.** On `rise`, go to CHECK with `good`=0.
- **CHECK, correct spacing.** `rise` with `ph`==3 increments `good`. When `good` reaches LOCK_COUNT-1, go to LOCKED.
- **CHECK, wrong spacing.** `rise` with `ph`!=3 clears `good` and stays in CHECK.
- **CHECK, missing edge.** `ph`==3 without `rise` returns to UNLOCKED.
- **LOCKED.** `rise` with `ph`!=3, or `ph`==3 without `rise`, returns to UNLOCKED.
- **Load request.** `req = locked & enable & (ph == latch_phase)`. `latch_en <= {MXSEGS{req}}`.
- **Frame start.** When `latch_en` is high on a clock edge, set `in_frame`=1 and `step`=0.
- **Step advance.** In any other cycle with `in_frame`: if `step`<3, `step` increments. If `step`==3 and no load occurs on that edge, `in_frame` clears.
- **Lock loss.** Leaving LOCKED clears `in_frame` on the same edge.
- **Step outputs.** `step_valid = in_frame & |segment_active` (combinational from registers and the input). `step_index = step`. `frame_start = in_frame & (step==0)`.
- **Saturation.** `frame_saturated = step_valid & (step==3)`.
- **Counter.** `sat_count` increments on `frame_saturated` and holds at all-ones. `cnt_reset` has priority over increment.
- **Enable deasserted mid-frame.** The current frame finishes its steps; no new load is issued.
- **Reset values.** All registers 0, FSM UNLOCKED, `in_frame`=0. Every output is 0 in the cycle after reset is sampled high.
- **Reset mid-frame.** The frame is abandoned; no further `step_valid`.

## Timing
- `frame_clock` rising at sample edge k gives `rise` high during the cycle after edge k+1. `ph`=0 from edge k+2.
- `latch_en` is high for exactly one cycle: the cycle after the cycle in which `ph`==`latch_phase`. The truncator loads on that edge.
- `step`=0 in the cycle after `latch_en`. Steps 0..3 occupy four consecutive cycles.
- In LOCKED, `latch_en` has period exactly 4 cycles, so frames are back-to-back with no idle step.
- LOCKED is asserted LOCK_COUNT+1 frame edges after the first edge while UNLOCKED (1 edge to enter CHECK, LOCK_COUNT good edges).
- A `latch_phase` change takes effect at the next `ph` match. A frame may be truncated or extended by up to 3 cycles, and is never duplicated within one 4-cycle period.

## Test plan
- **Lock acquisition.** Reset, then a clean 4-cycle `frame_clock` (2 high, 2 low) with `enable`=1, `latch_phase`=2 -> `locked` rises after the 5th detected edge. `latch_en` is all-ones once every 4 cycles, one cycle after `ph`==2. No `latch_en` before lock.
- **Step sequencing.** `segment_active` = 0x003 for steps 0..1, then 0 -> `step_valid` = 1,1,0,0; `step_index` = 0,1,2,3; `frame_start` pulses once; `frame_saturated` stays 0.
- **Saturation and counter.** `segment_active` nonzero for all four steps over 3 frames -> `frame_saturated` pulses at step 3 of each frame and `sat_count`=3. Preload near all-ones -> holds at 0xFFFF. `cnt_reset` together with a pulse -> `sat_count`=0.
- **Lock loss.** Delay one `frame_clock` edge by 1 cycle -> `locked` falls on the mismatched edge, `in_frame` clears, `step_valid`=0 and `latch_en`=0 until relock (5 good edges).
- **Enable drop mid-frame.** `enable`=0 at step 1 -> steps 2..3 complete, no further `latch_en`. Re-assert -> the next `ph` match issues `latch_en`.
- **Reset mid-frame.** `reset` at step 2 -> all outputs 0 next cycle, `locked`=0, `sat_count`=0. Relock needs 5 edges.
